xbar_interconnect: RTL and testbench
====================================

XBAR_INTERCONNECT -- requirements
Module: xbar_interconnect

Interface
REQ-001 Parameter NUM_MASTERS, default 2: number of master ports, range 1..16.
REQ-002 Parameter NUM_SLAVES, default 4: number of slave ports, range 1..16.
REQ-003 Parameter ADDR_WIDTH, default 32: address width.
REQ-004 Parameter DATA_WIDTH, default 32: data width.
REQ-005 Parameter SEL_LSB, default 14: LSB of the slave-select field; field is addr[SEL_LSB +: SEL_W], SEL_W = max(1, $clog2(NUM_SLAVES)).
REQ-006 clk  in  1  single clock; all state is on the rising edge.
REQ-007 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 i_m_req  in  [NUM_MASTERS]  master request valid.
REQ-009 i_m_we  in  [NUM_MASTERS]  1 = write, 0 = read.
REQ-010 i_m_addr  in  [NUM_MASTERS][ADDR_WIDTH]  request address.
REQ-011 i_m_wdata  in  [NUM_MASTERS][DATA_WIDTH]  write data.
REQ-012 o_m_gnt  out  [NUM_MASTERS]  one-cycle pulse: request accepted.
REQ-013 o_m_rvalid  out  [NUM_MASTERS]  one-cycle pulse: response (read data or write ack).
REQ-014 o_m_rdata  out  [NUM_MASTERS][DATA_WIDTH]  response data, valid with o_m_rvalid.
REQ-015 o_m_err  out  [NUM_MASTERS]  decode error, valid with o_m_rvalid.
REQ-016 o_s_req, o_s_we  out  [NUM_SLAVES]  slave request and direction.
REQ-017 o_s_addr, o_s_wdata  out  [NUM_SLAVES][ADDR_WIDTH / DATA_WIDTH]  registered request payload.
REQ-018 i_s_gnt  in  [NUM_SLAVES]  slave accepts the request while o_s_req = 1.
REQ-019 i_s_rvalid, i_s_rdata  in  [NUM_SLAVES], [NUM_SLAVES][DATA_WIDTH]  slave response.

Function
REQ-020 Each master SHALL have at most one outstanding transaction; i_m_req from a master with a pending transaction SHALL be ignored.
REQ-021 Each slave SHALL run an independent FSM: IDLE -> REQ (on grant) -> WAIT (on i_s_gnt = 1 at an edge) -> IDLE (on i_s_rvalid = 1 at an edge).
REQ-022 In IDLE, a per-slave round-robin arbiter SHALL select one eligible master whose decoded index equals that slave, assert its o_m_gnt in the same cycle, and register addr/wdata/we/owner.
REQ-023 The round-robin pointer SHALL be set to winner+1 (mod NUM_MASTERS) on each grant; after reset it SHALL be 0, giving master 0 highest priority.
REQ-024 In REQ, o_s_req SHALL be 1 and o_s_addr/o_s_wdata/o_s_we SHALL be held stable until i_s_gnt is sampled high; in IDLE and WAIT, o_s_req SHALL be 0.
REQ-025 i_s_rvalid SHALL be ignored outside WAIT; i_s_gnt SHALL be ignored outside REQ.
REQ-026 In WAIT, i_s_rvalid = 1 SHALL register i_s_rdata into o_m_rdata[owner] and pulse o_m_rvalid[owner] on the next cycle with o_m_err = 0.
REQ-027 A master's pending flag SHALL clear at the edge that raises its o_m_rvalid, so it is eligible in that cycle.
REQ-028 Minimum latency SHALL be: o_m_gnt in cycle N; o_s_req in N+1; if i_s_gnt in N+1 and i_s_rvalid in N+2, o_m_rvalid in N+3.
REQ-029 If the decoded index is >= NUM_SLAVES, the crossbar SHALL grant immediately, with no slave access, and pulse o_m_rvalid and o_m_err with o_m_rdata = 0 in the next cycle.
REQ-030 Different slaves SHALL serve different masters concurrently; responses to different masters in the same cycle SHALL all be delivered.
REQ-031 A slave returning to IDLE SHALL not accept a new grant in the cycle its response is captured; one idle cycle is required.
REQ-032 o_m_rdata SHALL hold its last value when o_m_rvalid is 0.

Reset
REQ-033 While rst_n = 0, all outputs, FSMs (IDLE), pending flags, owners and pointers SHALL be 0, asynchronously; this includes a reset in mid-transaction, which drops o_s_req immediately with no response issued.
REQ-034 The first active edge after rst_n deasserts SHALL be able to issue grants.

Verification
REQ-035 Single read: M0 reads 0x0000_4010 (slave 1); S1 gnt at N+1, rdata 0xDEADBEEF at N+2 -> o_m_rvalid[0] at N+3 with rdata 0xDEADBEEF, err 0.
REQ-036 Contention: M0 and M1 both request slave 2 every cycle -> grants alternate M0, M1, M0; no slave sees two requests at once.
REQ-037 Parallel: M0 targets slave 0 and M1 targets slave 3 in the same cycle -> both o_m_gnt are set in that cycle, and both responses arrive independently.
REQ-038 Decode error with NUM_SLAVES = 3: M1 reads 0x0000_C000 -> o_m_gnt[1] in N, then o_m_rvalid[1] = 1, o_m_err[1] = 1, rdata 0 at N+1; all o_s_req stay 0.
REQ-039 Backpressure/reset: hold i_s_gnt = 0 for 5 cycles -> o_s_addr is stable throughout; then assert rst_n = 0 -> o_s_req drops asynchronously, and M0 is eligible again after reset.

Source files
------------

// File: rtl/xbar_interconnect.sv
// Multi-master / multi-slave request crossbar with a per-slave round-robin arbiter
// and a three-state slave FSM; out-of-range addresses are answered with an error.
module xbar_interconnect #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int SEL_LSB     = 14
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_MASTERS-1:0]                 i_m_req,
    input  logic [NUM_MASTERS-1:0]                 i_m_we,
    input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] i_m_addr,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] i_m_wdata,
    output logic [NUM_MASTERS-1:0]                 o_m_gnt,
    output logic [NUM_MASTERS-1:0]                 o_m_rvalid,
    output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] o_m_rdata,
    output logic [NUM_MASTERS-1:0]                 o_m_err,
    output logic [NUM_SLAVES-1:0]                  o_s_req,
    output logic [NUM_SLAVES-1:0]                  o_s_we,
    output logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0]  o_s_addr,
    output logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0]  o_s_wdata,
    input  logic [NUM_SLAVES-1:0]                  i_s_gnt,
    input  logic [NUM_SLAVES-1:0]                  i_s_rvalid,
    input  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0]  i_s_rdata
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int MST_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [SEL_W:0] SLAVE_COUNT = (SEL_W+1)'(NUM_SLAVES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } slave_state_t;

    slave_state_t                  state   [NUM_SLAVES];
    logic [MST_W-1:0]              owner   [NUM_SLAVES];
    logic [MST_W-1:0]              rr_ptr  [NUM_SLAVES];
    logic [MST_W-1:0]              winner  [NUM_SLAVES];
    logic [NUM_SLAVES-1:0]         slv_win;

    logic [NUM_MASTERS-1:0]                 pending;
    logic [NUM_MASTERS-1:0]                 eligible;
    logic [NUM_MASTERS-1:0]                 dec_err;
    logic [NUM_MASTERS-1:0]                 gnt;
    logic [NUM_MASTERS-1:0][SEL_W-1:0]      sel;
    logic [NUM_MASTERS-1:0]                 resp_valid;
    logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] resp_data;

    function automatic logic [MST_W-1:0] next_ptr(input logic [MST_W-1:0] cur);
        if (int'(cur) == NUM_MASTERS - 1) return '0;
        return cur + 1'b1;
    endfunction

    // Decode and arbitration. Iterating from lowest priority upwards lets the
    // highest-priority eligible master overwrite the winner last.
    always_comb begin
        int idx;
        idx      = 0;
        eligible = i_m_req & ~pending;
        dec_err  = '0;
        gnt      = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            sel[m] = i_m_addr[m][SEL_LSB +: SEL_W];
            if (eligible[m] && ({1'b0, sel[m]} >= SLAVE_COUNT)) dec_err[m] = 1'b1;
        end
        gnt = dec_err;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            slv_win[s] = 1'b0;
            winner[s]  = '0;
            o_s_req[s] = (state[s] == S_REQ);
            if (state[s] == S_IDLE) begin
                for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
                    idx = int'(rr_ptr[s]) + k;
                    if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
                    if (eligible[idx] && (sel[idx] == SEL_W'(s))) begin
                        slv_win[s] = 1'b1;
                        winner[s]  = MST_W'(idx);
                    end
                end
            end
            if (slv_win[s]) gnt[winner[s]] = 1'b1;
        end
        o_m_gnt = rst_n ? gnt : '0;
    end

    // Response routing: at most one source per master since each has one outstanding.
    always_comb begin
        for (int m = 0; m < NUM_MASTERS; m++) begin
            resp_valid[m] = dec_err[m];
            resp_data[m]  = '0;
            for (int s = 0; s < NUM_SLAVES; s++) begin
                if ((state[s] == S_WAIT) && i_s_rvalid[s] && (owner[s] == MST_W'(m))) begin
                    resp_valid[m] = 1'b1;
                    resp_data[m]  = i_s_rdata[s];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SLAVES; s++) begin
                state[s]     <= S_IDLE;
                owner[s]     <= '0;
                rr_ptr[s]    <= '0;
                o_s_we[s]    <= 1'b0;
                o_s_addr[s]  <= '0;
                o_s_wdata[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NUM_SLAVES; s++) begin
                case (state[s])
                    S_IDLE: begin
                        if (slv_win[s]) begin
                            state[s]     <= S_REQ;
                            owner[s]     <= winner[s];
                            rr_ptr[s]    <= next_ptr(winner[s]);
                            o_s_we[s]    <= i_m_we[winner[s]];
                            o_s_addr[s]  <= i_m_addr[winner[s]];
                            o_s_wdata[s] <= i_m_wdata[winner[s]];
                        end
                    end
                    S_REQ:   if (i_s_gnt[s]) state[s] <= S_WAIT;
                    S_WAIT:  if (i_s_rvalid[s]) state[s] <= S_IDLE;
                    default: state[s] <= S_IDLE;
                endcase
            end
        end
    end

    // Pending clears on the same edge that raises rvalid, so a decode-error
    // master sets and clears in one step and is eligible again immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= '0;
            o_m_rvalid <= '0;
            o_m_err    <= '0;
            o_m_rdata  <= '0;
        end else begin
            pending    <= (pending | gnt) & ~resp_valid;
            o_m_rvalid <= resp_valid;
            o_m_err    <= dec_err;
            for (int m = 0; m < NUM_MASTERS; m++) begin
                if (resp_valid[m]) o_m_rdata[m] <= resp_data[m];
            end
        end
    end

endmodule

// File: tb/tb_xbar_interconnect.sv
// Directed bench for xbar_interconnect: a 2x4 instance for the main traffic and
// a 2x3 instance for out-of-range decode.
module tb_xbar_interconnect;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic [1:0]        m_req, m_we;
    logic [1:0][31:0]  m_addr, m_wdata;
    logic [1:0]        m_gnt, m_rvalid, m_err;
    logic [1:0][31:0]  m_rdata;
    logic [3:0]        s_req, s_we, s_gnt, s_rvalid;
    logic [3:0][31:0]  s_addr, s_wdata, s_rdata;

    logic [1:0]        m_req3;
    logic [1:0]        m_gnt3, m_rvalid3, m_err3;
    logic [1:0][31:0]  m_rdata3;
    logic [2:0]        s_req3, s_we3, s_gnt3, s_rvalid3;
    logic [2:0][31:0]  s_addr3, s_wdata3, s_rdata3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xbar_interconnect #(.NUM_MASTERS(2), .NUM_SLAVES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_m_req(m_req), .i_m_we(m_we), .i_m_addr(m_addr), .i_m_wdata(m_wdata),
        .o_m_gnt(m_gnt), .o_m_rvalid(m_rvalid), .o_m_rdata(m_rdata), .o_m_err(m_err),
        .o_s_req(s_req), .o_s_we(s_we), .o_s_addr(s_addr), .o_s_wdata(s_wdata),
        .i_s_gnt(s_gnt), .i_s_rvalid(s_rvalid), .i_s_rdata(s_rdata)
    );

    xbar_interconnect #(.NUM_MASTERS(2), .NUM_SLAVES(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .i_m_req(m_req3), .i_m_we(m_we), .i_m_addr(m_addr), .i_m_wdata(m_wdata),
        .o_m_gnt(m_gnt3), .o_m_rvalid(m_rvalid3), .o_m_rdata(m_rdata3), .o_m_err(m_err3),
        .o_s_req(s_req3), .o_s_we(s_we3), .o_s_addr(s_addr3), .o_s_wdata(s_wdata3),
        .i_s_gnt(s_gnt3), .i_s_rvalid(s_rvalid3), .i_s_rdata(s_rdata3)
    );

    task automatic applyStimulus(input logic [1:0] req, input logic [1:0] we,
                                 input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [31:0] w0, input logic [31:0] w1);
        m_req     = req;
        m_we      = we;
        m_addr[0] = a0;
        m_addr[1] = a1;
        m_wdata[0] = w0;
        m_wdata[1] = w1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic cycleEnd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        m_req3 = 2'b00;
        s_gnt = '0; s_rvalid = '0; s_rdata = '0;
        s_gnt3 = '0; s_rvalid3 = '0; s_rdata3 = '0;

        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_gnt",    32'(m_gnt),    32'h0);
        checkOutput("reset_rvalid", 32'(m_rvalid), 32'h0);
        checkOutput("reset_s_req",  32'(s_req),    32'h0);
        checkOutput("reset_rdata0", m_rdata[0],    32'h0);
        @(posedge clk);
        cycleEnd();
        rst_n = 1'b1;

        $display("[TB] single read");
        applyStimulus(2'b01, 2'b00, 32'h0000_4010, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("rd_gnt_N", 32'(m_gnt), 32'h1);
        checkOutput("rd_sreq_N", 32'(s_req), 32'h0);
        cycleEnd();
        s_gnt[1] = 1'b1;
        @(negedge clk);
        checkOutput("rd_sreq_N1", 32'(s_req), 32'h2);
        checkOutput("rd_saddr_N1", s_addr[1], 32'h0000_4010);
        checkOutput("rd_swe_N1", 32'(s_we[1]), 32'h0);
        checkOutput("rd_pending_ignored", 32'(m_gnt), 32'h0);
        cycleEnd();
        m_req = 2'b00;
        s_gnt = '0; s_rvalid[1] = 1'b1; s_rdata[1] = 32'hDEAD_BEEF;
        @(negedge clk);
        checkOutput("rd_sreq_N2", 32'(s_req), 32'h0);
        checkOutput("rd_rvalid_N2", 32'(m_rvalid), 32'h0);
        cycleEnd();
        s_rvalid = '0;
        @(negedge clk);
        checkOutput("rd_rvalid_N3", 32'(m_rvalid), 32'h1);
        checkOutput("rd_rdata_N3", m_rdata[0], 32'hDEAD_BEEF);
        checkOutput("rd_err_N3", 32'(m_err), 32'h0);
        cycleEnd();
        @(negedge clk);
        checkOutput("rd_rvalid_N4", 32'(m_rvalid), 32'h0);
        checkOutput("rd_rdata_hold", m_rdata[0], 32'hDEAD_BEEF);
        cycleEnd();

        $display("[TB] contention on slave 2");
        applyStimulus(2'b11, 2'b00, 32'h0000_8000, 32'h0000_8000, 32'h0, 32'h0);
        s_gnt[2] = 1'b1; s_rvalid[2] = 1'b1; s_rdata[2] = 32'h2222_0000;
        @(negedge clk);
        checkOutput("ct_gnt_C0", 32'(m_gnt), 32'h1);
        cycleEnd();
        @(negedge clk);
        checkOutput("ct_gnt_C1", 32'(m_gnt), 32'h0);
        checkOutput("ct_sreq_C1", 32'(s_req), 32'h4);
        cycleEnd();
        @(negedge clk);
        checkOutput("ct_gnt_C2", 32'(m_gnt), 32'h0);
        cycleEnd();
        @(negedge clk);
        checkOutput("ct_gnt_C3", 32'(m_gnt), 32'h2);
        checkOutput("ct_rvalid_C3", 32'(m_rvalid), 32'h1);
        checkOutput("ct_rdata_C3", m_rdata[0], 32'h2222_0000);
        cycleEnd();
        @(negedge clk);
        checkOutput("ct_sreq_C4", 32'(s_req), 32'h4);
        checkOutput("ct_saddr_C4", s_addr[2], 32'h0000_8000);
        cycleEnd();
        cycleEnd();
        @(negedge clk);
        checkOutput("ct_gnt_C6", 32'(m_gnt), 32'h1);
        checkOutput("ct_rvalid_C6", 32'(m_rvalid), 32'h2);
        checkOutput("ct_rdata_C6", m_rdata[1], 32'h2222_0000);
        cycleEnd();
        m_req = 2'b00;
        for (int i = 0; i < 4; i++) cycleEnd();
        s_gnt = '0; s_rvalid = '0;

        $display("[TB] parallel access to slaves 0 and 3");
        applyStimulus(2'b11, 2'b11, 32'h0000_0100, 32'h0000_C004, 32'h1111_0000, 32'h0000_3333);
        @(negedge clk);
        checkOutput("pa_gnt_P", 32'(m_gnt), 32'h3);
        cycleEnd();
        m_req = 2'b00;
        s_gnt = 4'b0001;
        @(negedge clk);
        checkOutput("pa_sreq_P1", 32'(s_req), 32'h9);
        checkOutput("pa_swe_P1", 32'(s_we), 32'h9);
        checkOutput("pa_swdata0", s_wdata[0], 32'h1111_0000);
        checkOutput("pa_swdata3", s_wdata[3], 32'h0000_3333);
        cycleEnd();
        s_gnt = 4'b1000; s_rvalid = 4'b0001; s_rdata[0] = 32'h0000_AAAA;
        @(negedge clk);
        checkOutput("pa_sreq_P2", 32'(s_req), 32'h8);
        cycleEnd();
        s_gnt = '0; s_rvalid = 4'b1000; s_rdata[3] = 32'h3333_0001;
        @(negedge clk);
        checkOutput("pa_rvalid_P3", 32'(m_rvalid), 32'h1);
        checkOutput("pa_rdata0_P3", m_rdata[0], 32'h0000_AAAA);
        cycleEnd();
        s_rvalid = '0;
        @(negedge clk);
        checkOutput("pa_rvalid_P4", 32'(m_rvalid), 32'h2);
        checkOutput("pa_rdata1_P4", m_rdata[1], 32'h3333_0001);
        checkOutput("pa_err_P4", 32'(m_err), 32'h0);
        cycleEnd();

        $display("[TB] decode error on 3-slave instance");
        applyStimulus(2'b00, 2'b00, 32'h0, 32'h0000_C000, 32'h0, 32'h0);
        m_req3 = 2'b10;
        @(negedge clk);
        checkOutput("de_gnt_D", 32'(m_gnt3), 32'h2);
        checkOutput("de_sreq_D", 32'(s_req3), 32'h0);
        cycleEnd();
        @(negedge clk);
        checkOutput("de_rvalid_D1", 32'(m_rvalid3), 32'h2);
        checkOutput("de_err_D1", 32'(m_err3), 32'h2);
        checkOutput("de_rdata_D1", m_rdata3[1], 32'h0);
        checkOutput("de_regrant_D1", 32'(m_gnt3), 32'h2);
        checkOutput("de_sreq_D1", 32'(s_req3), 32'h0);
        cycleEnd();
        m_req3 = 2'b00;
        @(negedge clk);
        checkOutput("de_rvalid_D2", 32'(m_rvalid3), 32'h2);
        checkOutput("de_gnt_D2", 32'(m_gnt3), 32'h0);
        cycleEnd();
        @(negedge clk);
        checkOutput("de_rvalid_D3", 32'(m_rvalid3), 32'h0);
        checkOutput("de_err_D3", 32'(m_err3), 32'h0);
        cycleEnd();

        $display("[TB] backpressure and mid-transaction reset");
        applyStimulus(2'b01, 2'b00, 32'h0000_4444, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("bp_gnt", 32'(m_gnt), 32'h1);
        cycleEnd();
        applyStimulus(2'b00, 2'b00, 32'hFFFF_0000, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_sreq_hold", 32'(s_req), 32'h2);
            checkOutput("bp_saddr_hold", s_addr[1], 32'h0000_4444);
            cycleEnd();
        end
        #2 rst_n = 1'b0;
        applyStimulus(2'b01, 2'b00, 32'h0000_4010, 32'h0, 32'h0, 32'h0);
        #1;
        checkOutput("rst_sreq_async", 32'(s_req), 32'h0);
        checkOutput("rst_saddr_async", s_addr[1], 32'h0);
        checkOutput("rst_gnt_blocked", 32'(m_gnt), 32'h0);
        checkOutput("rst_rvalid", 32'(m_rvalid), 32'h0);
        cycleEnd();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_gnt", 32'(m_gnt), 32'h1);
        cycleEnd();
        m_req = 2'b00;
        @(negedge clk);
        checkOutput("post_rst_sreq", 32'(s_req), 32'h2);
        checkOutput("post_rst_saddr", s_addr[1], 32'h0000_4010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
